lin_crc_arbiter: RTL and testbench

- Shares one combinational crcd64_o8 CRC8 engine between two requesters: the LIN TX frame builder and the LIN RX frame checker.
- Each requester presents a 64-bit data word. The block arbitrates round-robin, registers the operand, and allows a multi-cycle path through the CRC logic.
- Returns the CRC to the winner. For RX it also compares the result against the received CRC byte.
- Sits between the LIN TX/RX controllers and the single CRC instance it owns.

---
 rtl/lin_crc_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_lin_crc_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lin_crc_arbiter.sv
// Round-robin arbiter sharing one combinational CRC-8 (poly 0x07) engine between LIN TX and RX.
// Optional RX mismatch counter is compiled in with `define LIN_CRC_ERRCNT_EN.

module crcd64_o8 (
  input  logic [63:0] data,
  input  logic [7:0]  crc_in,
  output logic [7:0]  crc_out
);
  // Bit-serial CRC unrolled into 64 stages, data bit 63 enters first.
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_bit
      logic [7:0] crc_prev;
      logic [7:0] crc_cur;
      if (gi == 0) begin : g_first
        assign crc_prev = crc_in;
      end else begin : g_rest
        assign crc_prev = g_bit[gi-1].crc_cur;
      end
      assign crc_cur = {crc_prev[6:0], 1'b0} ^ ({8{crc_prev[7] ^ data[63-gi]}} & 8'h07);
    end
  endgenerate

  assign crc_out = g_bit[63].crc_cur;
endmodule

module lin_crc_arbiter #(
  parameter logic [7:0]  SEED        = 8'hFF,
  parameter int unsigned CALC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_req,
  input  logic [63:0] tx_data,
  output logic        tx_ack,
  output logic        tx_done,
  output logic [7:0]  tx_crc,
  input  logic        rx_req,
  input  logic [63:0] rx_data,
  input  logic [7:0]  rx_crc_exp,
  output logic        rx_ack,
  output logic        rx_done,
  output logic [7:0]  rx_crc,
  output logic        rx_crc_ok,
  output logic        busy,
  output logic [7:0]  err_cnt,
  input  logic        err_clr
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(CALC_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  count_reg, count_next;
  logic        grant_rx_reg, grant_rx_next;
  logic        last_rx_reg, last_rx_next;
  logic [63:0] operand_reg, operand_next;
  logic [7:0]  exp_reg, exp_next;
  logic        tx_ack_reg, tx_ack_next;
  logic        rx_ack_reg, rx_ack_next;
  logic        tx_done_reg, tx_done_next;
  logic        rx_done_reg, rx_done_next;
  logic [7:0]  tx_crc_reg, tx_crc_next;
  logic [7:0]  rx_crc_reg, rx_crc_next;
  logic        rx_crc_ok_reg, rx_crc_ok_next;
  logic        pick_rx;
  logic [7:0]  crc_out;

  // Operand is registered, so the engine path may span CALC_CYCLES clocks.
  crcd64_o8 u_crc (
    .data    (operand_reg),
    .crc_in  (SEED),
    .crc_out (crc_out)
  );

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    grant_rx_next  = grant_rx_reg;
    last_rx_next   = last_rx_reg;
    operand_next   = operand_reg;
    exp_next       = exp_reg;
    tx_ack_next    = 1'b0;
    rx_ack_next    = 1'b0;
    tx_done_next   = 1'b0;
    rx_done_next   = 1'b0;
    tx_crc_next    = tx_crc_reg;
    rx_crc_next    = rx_crc_reg;
    rx_crc_ok_next = rx_crc_ok_reg;
    pick_rx        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (tx_req || rx_req) begin
          // On a tie the requester not served last wins.
          pick_rx       = rx_req && (!tx_req || !last_rx_reg);
          grant_rx_next = pick_rx;
          last_rx_next  = pick_rx;
          operand_next  = pick_rx ? rx_data : tx_data;
          if (pick_rx) begin
            exp_next = rx_crc_exp;
          end
          tx_ack_next = !pick_rx;
          rx_ack_next = pick_rx;
          count_next  = CNT_LOAD;
          state_next  = CALC;
        end
      end
      CALC: begin
        if (count_reg == 4'd0) begin
          if (grant_rx_reg) begin
            rx_crc_next    = crc_out;
            rx_crc_ok_next = (crc_out == exp_reg);
            rx_done_next   = 1'b1;
          end else begin
            tx_crc_next  = crc_out;
            tx_done_next = 1'b1;
          end
          state_next = DONE;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= 4'd0;
      grant_rx_reg  <= 1'b0;
      last_rx_reg   <= 1'b1;
      operand_reg   <= 64'd0;
      exp_reg       <= 8'd0;
      tx_ack_reg    <= 1'b0;
      rx_ack_reg    <= 1'b0;
      tx_done_reg   <= 1'b0;
      rx_done_reg   <= 1'b0;
      tx_crc_reg    <= 8'd0;
      rx_crc_reg    <= 8'd0;
      rx_crc_ok_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      grant_rx_reg  <= grant_rx_next;
      last_rx_reg   <= last_rx_next;
      operand_reg   <= operand_next;
      exp_reg       <= exp_next;
      tx_ack_reg    <= tx_ack_next;
      rx_ack_reg    <= rx_ack_next;
      tx_done_reg   <= tx_done_next;
      rx_done_reg   <= rx_done_next;
      tx_crc_reg    <= tx_crc_next;
      rx_crc_reg    <= rx_crc_next;
      rx_crc_ok_reg <= rx_crc_ok_next;
    end
  end

  assign tx_ack    = tx_ack_reg;
  assign rx_ack    = rx_ack_reg;
  assign tx_done   = tx_done_reg;
  assign rx_done   = rx_done_reg;
  assign tx_crc    = tx_crc_reg;
  assign rx_crc    = rx_crc_reg;
  assign rx_crc_ok = rx_crc_ok_reg;
  assign busy      = (state_reg != IDLE);

`ifdef LIN_CRC_ERRCNT_EN
  logic [7:0] err_cnt_reg, err_cnt_next;

  // Counts during the DONE cycle of a failed RX check; clear wins.
  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (err_clr) begin
      err_cnt_next = 8'd0;
    end else if (state_reg == DONE && grant_rx_reg && !rx_crc_ok_reg && err_cnt_reg != 8'hFF) begin
      err_cnt_next = err_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_reg <= 8'd0;
    end else begin
      err_cnt_reg <= err_cnt_next;
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = 8'h00;
`endif
endmodule

// File: tb/tb_lin_crc_arbiter.sv
// Bench for lin_crc_arbiter: two instances (SEED FF/1 cycle, SEED 00/4 cycles) share stimulus
// and are checked every cycle against a transaction-level model.
module tb_lin_crc_arbiter;
  localparam int ND = 2;
  localparam logic [7:0] SEED0 = 8'hFF;
  localparam logic [7:0] SEED1 = 8'h00;
  localparam int CC0 = 1;
  localparam int CC1 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_req = 1'b0, rx_req = 1'b0, err_clr = 1'b0;
  logic [63:0] tx_data = 64'd0, rx_data = 64'd0;
  logic [7:0] rx_crc_exp = 8'd0;

  logic tx_ack [ND], tx_done [ND], rx_ack [ND], rx_done [ND], rx_crc_ok [ND], busy [ND];
  logic [7:0] tx_crc [ND], rx_crc [ND], err_cnt [ND];

  int n_cmp = 0;
  int n_bad = 0;
  int ecount = 0;

  always #5 clk = ~clk;

  lin_crc_arbiter #(.SEED(SEED0), .CALC_CYCLES(CC0)) dut0 (
    .clk(clk), .rst(rst),
    .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack[0]), .tx_done(tx_done[0]), .tx_crc(tx_crc[0]),
    .rx_req(rx_req), .rx_data(rx_data), .rx_crc_exp(rx_crc_exp), .rx_ack(rx_ack[0]),
    .rx_done(rx_done[0]), .rx_crc(rx_crc[0]), .rx_crc_ok(rx_crc_ok[0]),
    .busy(busy[0]), .err_cnt(err_cnt[0]), .err_clr(err_clr)
  );

  lin_crc_arbiter #(.SEED(SEED1), .CALC_CYCLES(CC1)) dut1 (
    .clk(clk), .rst(rst),
    .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack[1]), .tx_done(tx_done[1]), .tx_crc(tx_crc[1]),
    .rx_req(rx_req), .rx_data(rx_data), .rx_crc_exp(rx_crc_exp), .rx_ack(rx_ack[1]),
    .rx_done(rx_done[1]), .rx_crc(rx_crc[1]), .rx_crc_ok(rx_crc_ok[1]),
    .busy(busy[1]), .err_cnt(err_cnt[1]), .err_clr(err_clr)
  );

  // CRC as the remainder of (seed*x^64 + data*x^8) modulo x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc(input logic [63:0] d, input logic [7:0] seed);
    logic [71:0] r;
    r = {seed, 64'h0} ^ {d, 8'h0};
    for (int i = 71; i >= 8; i--) begin
      if (r[i]) r = r ^ (72'h107 << (i - 8));
    end
    return r[7:0];
  endfunction

  function automatic int cc_of(input int d);
    return (d == 0) ? CC0 : CC1;
  endfunction

  function automatic logic [7:0] seed_of(input int d);
    return (d == 0) ? SEED0 : SEED1;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, d, ecount, act, req);
    end
  endtask

  // Model: expected outputs after each edge, derived from transaction start edges.
  logic m_tx_ack [ND], m_rx_ack [ND], m_tx_done [ND], m_rx_done [ND], m_rx_ok [ND], m_busy [ND];
  logic [7:0] m_tx_crc [ND], m_rx_crc [ND], m_err [ND], m_pend_crc [ND], m_pend_exp [ND];
  bit m_active [ND], m_grx [ND], m_last_rx [ND];
  int m_s [ND], m_free [ND];

  initial begin
    forever begin
      @(posedge clk);
      ecount++;
      for (int d = 0; d < ND; d++) begin
        if (rst) begin
          m_tx_ack[d] = 0; m_rx_ack[d] = 0; m_tx_done[d] = 0; m_rx_done[d] = 0;
          m_rx_ok[d] = 0; m_busy[d] = 0; m_tx_crc[d] = 0; m_rx_crc[d] = 0; m_err[d] = 0;
          m_active[d] = 0; m_last_rx[d] = 1; m_free[d] = ecount + 1;
        end else begin
          m_tx_ack[d] = 0; m_rx_ack[d] = 0; m_tx_done[d] = 0; m_rx_done[d] = 0;
`ifdef LIN_CRC_ERRCNT_EN
          if (err_clr) m_err[d] = 0;
          else if (m_active[d] && ecount == m_s[d] + cc_of(d) + 1 && m_grx[d] && !m_rx_ok[d] && m_err[d] != 8'hFF)
            m_err[d] = m_err[d] + 8'd1;
`endif
          if (m_active[d] && ecount == m_s[d] + cc_of(d)) begin
            if (m_grx[d]) begin
              m_rx_crc[d] = m_pend_crc[d];
              m_rx_ok[d] = (m_pend_crc[d] == m_pend_exp[d]);
              m_rx_done[d] = 1;
            end else begin
              m_tx_crc[d] = m_pend_crc[d];
              m_tx_done[d] = 1;
            end
          end
          if (m_active[d] && ecount == m_s[d] + cc_of(d) + 1) m_active[d] = 0;
          if (ecount >= m_free[d] && (tx_req || rx_req)) begin
            m_grx[d] = (tx_req && rx_req) ? !m_last_rx[d] : rx_req;
            m_last_rx[d] = m_grx[d];
            m_active[d] = 1;
            m_s[d] = ecount;
            m_free[d] = ecount + cc_of(d) + 2;
            m_pend_crc[d] = ref_crc(m_grx[d] ? rx_data : tx_data, seed_of(d));
            m_pend_exp[d] = rx_crc_exp;
            if (m_grx[d]) m_rx_ack[d] = 1; else m_tx_ack[d] = 1;
          end
          m_busy[d] = m_active[d] && (ecount <= m_s[d] + cc_of(d));
        end
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (ecount > 0) begin
        for (int d = 0; d < ND; d++) begin
          chk("tx_ack", d, tx_ack[d], m_tx_ack[d]);
          chk("rx_ack", d, rx_ack[d], m_rx_ack[d]);
          chk("tx_done", d, tx_done[d], m_tx_done[d]);
          chk("rx_done", d, rx_done[d], m_rx_done[d]);
          chk("tx_crc", d, tx_crc[d], m_tx_crc[d]);
          chk("rx_crc", d, rx_crc[d], m_rx_crc[d]);
          chk("rx_crc_ok", d, rx_crc_ok[d], m_rx_ok[d]);
          chk("busy", d, busy[d], m_busy[d]);
          chk("err_cnt", d, err_cnt[d], m_err[d]);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy[0] || busy[1]) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout cycle %0d: busy still high, expected low", ecount);
    end
  endtask

  task automatic issue(input bit t, input bit r, input logic [63:0] td, input logic [63:0] rd,
                       input logic [7:0] ex, input bit clr, input bit wait_done, output bit won_rx);
    int n;
    bit seen0, seen1;
    wait_idle();
    #1;
    tx_req = t; rx_req = r; tx_data = td; rx_data = rd; rx_crc_exp = ex; err_clr = clr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_ack[0] || rx_ack[0]) && n < 20);
    chk("ack_latency", 0, n, 1);
    won_rx = rx_ack[0];
    $display("txn cycle %0d: tx_req=%0b rx_req=%0b granted=%s", ecount, t, r, won_rx ? "RX" : "TX");
    #1;
    // Requests drop and operands change during CALC; results must not move.
    tx_req = 0; rx_req = 0; err_clr = 0;
    tx_data = {$urandom, $urandom}; rx_data = {$urandom, $urandom}; rx_crc_exp = 8'($urandom);
    if (wait_done) begin
      seen0 = 0; seen1 = 0; n = 0;
      while (!(seen0 && seen1) && n < 40) begin
        @(negedge clk);
        n++;
        if (!seen0 && (tx_done[0] || rx_done[0])) begin seen0 = 1; chk("done_latency", 0, n, CC0); end
        if (!seen1 && (tx_done[1] || rx_done[1])) begin seen1 = 1; chk("done_latency", 1, n, CC1); end
      end
      if (!(seen0 && seen1)) begin
        n_cmp++; n_bad++;
        $display("FAIL done_timeout cycle %0d: done not seen, expected within %0d cycles", ecount, CC1);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit w;
    logic [63:0] rd;
    logic [7:0] c0, c1, ex;
    int n;

    chk("pin_crc_zero_ff", 0, ref_crc(64'h0, 8'hFF), 8'hDB);
    chk("pin_crc_one_00", 1, ref_crc(64'h1, 8'h00), 8'h07);

    repeat (3) @(negedge clk);
    chk("reset_tx_crc", 0, tx_crc[0], 0);
    chk("reset_busy", 1, busy[1], 0);
    #1 rst = 0;

    issue(1, 0, 64'h0, 64'h0, 8'h00, 0, 1, w);
    chk("tx_crc_zero", 0, tx_crc[0], 8'hDB);
    chk("first_grant", 0, w, 0);

    issue(0, 1, 64'h0, 64'h1, 8'h07, 0, 1, w);
    chk("rx_crc_one", 1, rx_crc[1], 8'h07);
    chk("rx_ok_match", 1, rx_crc_ok[1], 1);

    issue(0, 1, 64'h0, 64'h1, 8'h00, 0, 1, w);
    chk("rx_ok_mismatch", 1, rx_crc_ok[1], 0);
    @(negedge clk);
`ifdef LIN_CRC_ERRCNT_EN
    chk("err_cnt_one", 1, err_cnt[1], 1);
`endif

    // Simultaneous requests alternate, starting with TX since RX was served last.
    issue(1, 1, {$urandom, $urandom}, {$urandom, $urandom}, 8'h5A, 0, 1, w);
    chk("arb_both_1", 0, w, 0);
    issue(1, 1, {$urandom, $urandom}, {$urandom, $urandom}, 8'h5A, 0, 1, w);
    chk("arb_both_2", 0, w, 1);
    issue(1, 1, {$urandom, $urandom}, {$urandom, $urandom}, 8'h5A, 0, 1, w);
    chk("arb_both_3", 0, w, 0);

    // Reset while the 4-cycle instance is mid-calculation.
    issue(0, 1, {$urandom, $urandom}, 64'h1, 8'h07, 0, 0, w);
    @(negedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rst_mid_rx_done", 1, rx_done[1], 0);
    chk("rst_mid_rx_crc", 1, rx_crc[1], 0);
    chk("rst_mid_busy", 1, busy[1], 0);
    #1 rst = 0;
    issue(0, 1, 64'h0, 64'h1, 8'h07, 0, 1, w);
    chk("post_rst_rx_crc", 1, rx_crc[1], 8'h07);

    for (int i = 0; i < 150; i++) begin
      bit t, r;
      t = 1'($urandom); r = 1'($urandom);
      if (!t && !r) t = 1;
      rd = {$urandom, $urandom};
      ex = ($urandom_range(0, 2) == 0) ? 8'($urandom) : ref_crc(rd, seed_of(int'($urandom_range(0, 1))));
      issue(t, r, {$urandom, $urandom}, rd, ex, ($urandom_range(0, 7) == 0), 1, w);
    end

`ifdef LIN_CRC_ERRCNT_EN
    for (int i = 0; i < 260; i++) begin
      rd = {$urandom, $urandom};
      c0 = ref_crc(rd, SEED0); c1 = ref_crc(rd, SEED1);
      ex = c1 ^ 8'h01;
      if (ex == c0) ex = c1 ^ 8'h02;
      issue(0, 1, 64'h0, rd, ex, 0, 1, w);
    end
    @(negedge clk);
    chk("err_sat", 1, err_cnt[1], 8'hFF);
    chk("err_sat", 0, err_cnt[0], 8'hFF);

    rd = {$urandom, $urandom};
    ex = ref_crc(rd, SEED1) ^ 8'h01;
    issue(0, 1, 64'h0, rd, ex, 0, 0, w);
    n = 0;
    while (!rx_done[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("clr_done_seen", 1, rx_done[1], 1);
    #1 err_clr = 1;
    @(negedge clk);
    chk("err_clr_priority", 1, err_cnt[1], 0);
    #1 err_clr = 0;
`endif

    wait_idle();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
